// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the downstream reset. It retries on lock timeout and re-sequences when lock is lost.
module pll_reset_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retries,
  output logic [7:0] loss_count
);

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAILED    = 3'd4;

  localparam int CNT_MAX_AB = (PLL_RST_CYCLES > LOCK_CYCLES) ? PLL_RST_CYCLES : LOCK_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_AB > TIMEOUT_CYCLES) ? CNT_MAX_AB : TIMEOUT_CYCLES;
  // The counter only ever holds values up to CNT_MAX-1.
  localparam int CNT_W      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);

  logic             lock_meta;
  logic             lock_s;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       retries_nxt;
  logic [7:0]       loss_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    retries_nxt = retries;
    loss_nxt    = loss_count;
    if (restart) begin
      state_nxt   = ST_PLL_RST;
      cnt_nxt     = '0;
      retries_nxt = '0;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (cnt == RST_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TO_LAST) begin
            cnt_nxt = '0;
            if (retries == RETRY_LIM) begin
              state_nxt = ST_FAILED;
            end else begin
              state_nxt   = ST_PLL_RST;
              retries_nxt = retries + 2'd1;
            end
          end
        end
        ST_STABLE: begin
          // Any dropout restarts the timeout window without spending a retry.
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == LOCK_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end
        ST_RUN: begin
          cnt_nxt = '0;
          if (!lock_s) begin
            state_nxt   = ST_PLL_RST;
            retries_nxt = '0;
            loss_nxt    = sat_inc8(loss_count);
          end
        end
        ST_FAILED: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = ST_PLL_RST;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      state       <= ST_PLL_RST;
      cnt         <= '0;
      retries     <= '0;
      loss_count  <= '0;
      pll_resetb  <= 1'b0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      lock_meta   <= pll_locked;
      lock_s      <= lock_meta;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retries     <= retries_nxt;
      loss_count  <= loss_nxt;
      // Outputs come from the next state so they change on the transition edge.
      pll_resetb  <= !((state_nxt == ST_PLL_RST) || (state_nxt == ST_FAILED));
      sys_reset_n <= (state_nxt == ST_RUN);
      ready       <= (state_nxt == ST_RUN);
      fail        <= (state_nxt == ST_FAILED);
    end
  end

endmodule
